// File: rtl/pipesub3_pkg.sv
// Shared defaults and types for the clk_pipesub3 three-operand subtractor.
package pipesub3_pkg;

  localparam int PIPESUB3_WIDTH_DEF = 16;
  localparam int PIPESUB3_CNT_W_DEF = 16;

  typedef logic [15:0] pipesub3_word_t;

endpackage

// File: rtl/subripple_n.sv
// Combinational ripple-borrow subtractor: d = a - b mod 2^WIDTH, bout = (a < b).
module subripple_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  logic br;

  always_comb begin
    d  = '0;
    br = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      // Borrow out of this bit: a<b here, or equal bits with a borrow coming in.
      br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/clk_pipesub3.sv
// Two-stage valid/ready pipelined subtractor c = sum - a - b, with a transfer counter.
// Optional borrow output enabled by defining CLK_PIPESUB3_BORROW_EN.
module clk_pipesub3
  import pipesub3_pkg::*;
#(
  parameter int WIDTH = PIPESUB3_WIDTH_DEF,
  parameter int CNT_W = PIPESUB3_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
`ifdef CLK_PIPESUB3_BORROW_EN
  output logic             borrow,
`endif
  output logic [CNT_W-1:0] out_count
);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [WIDTH-1:0] d1_q, d1_d, b1_q, b1_d;
  logic [WIDTH-1:0] c_q, c_d, c_w;
  logic [WIDTH-1:0] d1_w;
  logic             br1_w, br2_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv2, in_fire, out_fire;

  subripple_n #(.WIDTH(WIDTH)) u_s1 (.a(sum),  .b(a),    .d(d1_w), .bout(br1_w));
  subripple_n #(.WIDTH(WIDTH)) u_s2 (.a(d1_q), .b(b1_q), .d(c_w),  .bout(br2_w));

  assign adv2     = v1_q && (!v2_q || out_ready);
  assign in_ready = !v1_q || adv2;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = v2_q && out_ready;

  always_comb begin
    v1_d  = v1_q;
    d1_d  = d1_q;
    b1_d  = b1_q;
    v2_d  = v2_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    if (in_fire) begin
      v1_d = 1'b1;
      d1_d = d1_w;
      b1_d = b;
    end else if (adv2) begin
      v1_d = 1'b0;
    end
    // S2 reloads on adv2 even when its current entry leaves in the same cycle.
    if (adv2) begin
      v2_d = 1'b1;
      c_d  = c_w;
    end else if (out_fire) begin
      v2_d = 1'b0;
    end
    if (out_fire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      d1_q  <= '0;
      b1_q  <= '0;
      v2_q  <= 1'b0;
      c_q   <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      d1_q  <= d1_d;
      b1_q  <= b1_d;
      v2_q  <= v2_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef CLK_PIPESUB3_BORROW_EN
  logic br1_q, br1_d, bo_q, bo_d;

  always_comb begin
    br1_d = br1_q;
    bo_d  = bo_q;
    if (in_fire) br1_d = br1_w;
    if (adv2)    bo_d  = br1_q | br2_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br1_q <= 1'b0;
      bo_q  <= 1'b0;
    end else begin
      br1_q <= br1_d;
      bo_q  <= bo_d;
    end
  end

  assign borrow = bo_q;
`else
  logic unused_br;
  assign unused_br = br1_w ^ br2_w;
`endif

  assign out_valid = v2_q;
  assign c         = c_q;
  assign out_count = cnt_q;

endmodule
